// File: rtl/pipe_stage_reg_if.sv
// Bundle of the pipeline-register signals between two pipeline stages.
//
// The master side (the upstream stage, or the bench) drives:
//   en, flush, valid_in, ir_in, pc_in, data_in, we_in,
//   tnew_in, exc_in, exc_local, bd_in
// The slave side (pipe_stage_reg) drives:
//   valid_out, ir_out, pc_out, data_out, we_out,
//   tnew_out, exc_out, bd_out, flush_cnt
//
// data_in and data_out pack N_DATA lanes. Lane 0 is in the least
// significant bits.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int N_DATA = 3,
    parameter int TNEW_W = 3,
    parameter int EXC_W  = 5,
    parameter int CNT_W  = 16
);
    // stage control
    logic                     en;
    logic                     flush;

    // inputs from the upstream stage
    logic                     valid_in;
    logic [DATA_W-1:0]        ir_in;
    logic [DATA_W-1:0]        pc_in;
    logic [N_DATA*DATA_W-1:0] data_in;
    logic                     we_in;
    logic [TNEW_W-1:0]        tnew_in;
    logic [EXC_W-1:0]         exc_in;
    logic [EXC_W-1:0]         exc_local;
    logic                     bd_in;

    // registered outputs
    logic                     valid_out;
    logic [DATA_W-1:0]        ir_out;
    logic [DATA_W-1:0]        pc_out;
    logic [N_DATA*DATA_W-1:0] data_out;
    logic                     we_out;
    logic [TNEW_W-1:0]        tnew_out;
    logic [EXC_W-1:0]         exc_out;
    logic                     bd_out;
    logic [CNT_W-1:0]         flush_cnt;

    modport master (
        output en, flush, valid_in, ir_in, pc_in, data_in, we_in,
               tnew_in, exc_in, exc_local, bd_in,
        input  valid_out, ir_out, pc_out, data_out, we_out,
               tnew_out, exc_out, bd_out, flush_cnt
    );

    modport slave (
        input  en, flush, valid_in, ir_in, pc_in, data_in, we_in,
               tnew_in, exc_in, exc_local, bd_in,
        output valid_out, ir_out, pc_out, data_out, we_out,
               tnew_out, exc_out, bd_out, flush_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised register between two stages of the five-stage MIPS pipeline.
// It is used for the D/E, E/M and M/W boundaries.
//
// Each rising edge does one of the following, highest priority first:
//   flush : loads a bubble. pc and bd are still taken from the inputs, so
//           EPC and BD stay correct. flush_cnt counts up and stops at all-ones.
//   !en   : holds every register, flush_cnt included.
//   load  : captures the stage inputs. Tnew counts down by one.
//
// An exception, from upstream or found in this cycle, kills the payload.
// pc, bd, valid and the merged exception code are kept.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   s     : pipe_stage_reg_if.slave (stage inputs and registered outputs)
module pipe_stage_reg #(
    parameter int          DATA_W   = 32,
    parameter int          N_DATA   = 3,
    parameter int          TNEW_W   = 3,
    parameter int          EXC_W    = 5,
    parameter int          CNT_W    = 16,
    parameter logic [31:0] RESET_PC = 32'h3000,
    parameter int          TNEW_DEC = 1
) (
    input  logic             clk,
    input  logic             reset,
    pipe_stage_reg_if.slave  s
);

    localparam int DW = N_DATA * DATA_W;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] ir_q,    ir_d;
    logic [DATA_W-1:0] pc_q,    pc_d;
    logic [DW-1:0]     data_q,  data_d;
    logic              we_q,    we_d;
    logic [TNEW_W-1:0] tnew_q,  tnew_d;
    logic [EXC_W-1:0]  exc_q,   exc_d;
    logic              bd_q,    bd_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic [EXC_W-1:0]  exc_m;
    logic [TNEW_W-1:0] tnew_dec;

    // An exception already recorded upstream is older than one found in
    // this cycle, so it has priority.
    assign exc_m = (s.exc_in != '0) ? s.exc_in : s.exc_local;

    // Tnew counts toward "result ready" and stops at 0 instead of wrapping.
    generate
        if (TNEW_DEC != 0) begin : g_tnew_dec
            assign tnew_dec = (s.tnew_in == '0) ? '0 : s.tnew_in - TNEW_W'(1);
        end else begin : g_tnew_pass
            assign tnew_dec = s.tnew_in;
        end
    endgenerate

    always_comb begin
        // The default is hold, which covers the stall case.
        valid_d = valid_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        data_d  = data_q;
        we_d    = we_q;
        tnew_d  = tnew_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        cnt_d   = cnt_q;

        if (s.flush) begin
            valid_d = 1'b0;
            ir_d    = '0;
            data_d  = '0;
            we_d    = 1'b0;
            tnew_d  = '0;
            exc_d   = '0;
            pc_d    = s.pc_in;
            bd_d    = s.bd_in;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (s.en) begin
            // pc and bd follow the slot in every load case.
            // They are needed for EPC and BD even when the slot is empty.
            pc_d = s.pc_in;
            bd_d = s.bd_in;
            if (!s.valid_in) begin
                // An upstream bubble: same as a flush, but it is not counted.
                valid_d = 1'b0;
                ir_d    = '0;
                data_d  = '0;
                we_d    = 1'b0;
                tnew_d  = '0;
                exc_d   = '0;
            end else if (exc_m != '0) begin
                // The instruction is killed. It stays valid so that the
                // exception reaches the commit point.
                valid_d = 1'b1;
                ir_d    = '0;
                data_d  = '0;
                we_d    = 1'b0;
                tnew_d  = '0;
                exc_d   = exc_m;
            end else begin
                valid_d = 1'b1;
                ir_d    = s.ir_in;
                data_d  = s.data_in;
                we_d    = s.we_in;
                tnew_d  = tnew_dec;
                exc_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ir_q    <= '0;
            pc_q    <= DATA_W'(RESET_PC);
            data_q  <= '0;
            we_q    <= 1'b0;
            tnew_q  <= '0;
            exc_q   <= '0;
            bd_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
            we_q    <= we_d;
            tnew_q  <= tnew_d;
            exc_q   <= exc_d;
            bd_q    <= bd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s.valid_out = valid_q;
    assign s.ir_out    = ir_q;
    assign s.pc_out    = pc_q;
    assign s.data_out  = data_q;
    assign s.we_out    = we_q;
    assign s.tnew_out  = tnew_q;
    assign s.exc_out   = exc_q;
    assign s.bd_out    = bd_q;
    assign s.flush_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg.
// dut_a uses the default parameters and runs the vector table.
// dut_b uses TNEW_DEC=0 and CNT_W=2. It runs the Tnew pass-through and the
// flush-counter saturation sequences.
module tb_pipe_stage_reg;

    typedef struct {
        logic        en, flush, valid, we, bd;
        logic [31:0] ir, pc;
        logic [95:0] data;
        logic [2:0]  tnew;
        logic [4:0]  exc, loc;
    } vin_t;

    typedef struct {
        logic        valid, we, bd;
        logic [31:0] ir, pc;
        logic [95:0] data;
        logic [2:0]  tnew;
        logic [4:0]  exc;
        logic [15:0] fc;
    } exp_t;

    typedef struct {
        vin_t i;
        exp_t e;
    } vec_t;

    localparam logic [95:0] D0 = 96'h00000033_00000022_00000011;
    localparam logic [95:0] D1 = 96'hAAAAAAAA_55555555_0F0F0F0F;

    logic clk = 1'b0;
    logic clk_run = 1'b1;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    vec_t vecs[13];

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    pipe_stage_reg_if #(.DATA_W(32), .N_DATA(3), .TNEW_W(3), .EXC_W(5), .CNT_W(16)) a_if ();
    pipe_stage_reg_if #(.DATA_W(32), .N_DATA(3), .TNEW_W(3), .EXC_W(5), .CNT_W(2))  b_if ();

    pipe_stage_reg #(.DATA_W(32), .N_DATA(3), .TNEW_W(3), .EXC_W(5), .CNT_W(16),
                     .RESET_PC(32'h3000), .TNEW_DEC(1)) dut_a (
        .clk(clk), .reset(reset), .s(a_if.slave));

    pipe_stage_reg #(.DATA_W(32), .N_DATA(3), .TNEW_W(3), .EXC_W(5), .CNT_W(2),
                     .RESET_PC(32'h3000), .TNEW_DEC(0)) dut_b (
        .clk(clk), .reset(reset), .s(b_if.slave));

    function automatic vec_t mk(
        input logic en, flush, valid, input logic [31:0] ir, pc, input logic [95:0] data,
        input logic we, input logic [2:0] tnew, input logic [4:0] exc, loc, input logic bd,
        input logic e_valid, input logic [31:0] e_ir, e_pc, input logic [95:0] e_data,
        input logic e_we, input logic [2:0] e_tnew, input logic [4:0] e_exc,
        input logic e_bd, input logic [15:0] e_fc);
        vec_t v;
        v.i.en = en; v.i.flush = flush; v.i.valid = valid; v.i.ir = ir; v.i.pc = pc;
        v.i.data = data; v.i.we = we; v.i.tnew = tnew; v.i.exc = exc; v.i.loc = loc;
        v.i.bd = bd;
        v.e.valid = e_valid; v.e.ir = e_ir; v.e.pc = e_pc; v.e.data = e_data;
        v.e.we = e_we; v.e.tnew = e_tnew; v.e.exc = e_exc; v.e.bd = e_bd; v.e.fc = e_fc;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive_a(input vin_t v);
        a_if.en = v.en; a_if.flush = v.flush; a_if.valid_in = v.valid;
        a_if.ir_in = v.ir; a_if.pc_in = v.pc; a_if.data_in = v.data; a_if.we_in = v.we;
        a_if.tnew_in = v.tnew; a_if.exc_in = v.exc; a_if.exc_local = v.loc; a_if.bd_in = v.bd;
    endtask

    task automatic drive_b(input vin_t v);
        b_if.en = v.en; b_if.flush = v.flush; b_if.valid_in = v.valid;
        b_if.ir_in = v.ir; b_if.pc_in = v.pc; b_if.data_in = v.data; b_if.we_in = v.we;
        b_if.tnew_in = v.tnew; b_if.exc_in = v.exc; b_if.exc_local = v.loc; b_if.bd_in = v.bd;
    endtask

    task automatic check_a(input string tag, input int idx, input exp_t e);
        chk({tag, ".valid"}, idx, 96'(a_if.valid_out), 96'(e.valid));
        chk({tag, ".ir"},    idx, 96'(a_if.ir_out),    96'(e.ir));
        chk({tag, ".pc"},    idx, 96'(a_if.pc_out),    96'(e.pc));
        chk({tag, ".data"},  idx, a_if.data_out,       e.data);
        chk({tag, ".we"},    idx, 96'(a_if.we_out),    96'(e.we));
        chk({tag, ".tnew"},  idx, 96'(a_if.tnew_out),  96'(e.tnew));
        chk({tag, ".exc"},   idx, 96'(a_if.exc_out),   96'(e.exc));
        chk({tag, ".bd"},    idx, 96'(a_if.bd_out),    96'(e.bd));
        chk({tag, ".fcnt"},  idx, 96'(a_if.flush_cnt), 96'(e.fc));
    endtask

    initial begin
        vin_t idle;
        vin_t vb;
        exp_t rst_e;
        exp_t got;
        logic [1:0] fexp [5];

        idle = '{en: 1'b0, flush: 1'b0, valid: 1'b0, we: 1'b0, bd: 1'b0,
                 ir: 32'h0, pc: 32'h0, data: 96'h0, tnew: 3'd0, exc: 5'd0, loc: 5'd0};
        rst_e = '{valid: 1'b0, we: 1'b0, bd: 1'b0, ir: 32'h0, pc: 32'h3000,
                  data: 96'h0, tnew: 3'd0, exc: 5'd0, fc: 16'd0};

        //             en fl v  ir            pc        data we tnew exc loc bd | v ir           pc        data we t  exc bd fc
        vecs[0]  = mk(1, 0, 1, 32'h8C010004, 32'h3010, D0, 1, 3'd2, 5'd0, 5'd0,  0, 1, 32'h8C010004, 32'h3010, D0, 1, 3'd1, 5'd0,  0, 16'd0);
        vecs[1]  = mk(1, 0, 1, 32'h00221820, 32'h3014, D1, 1, 3'd0, 5'd0, 5'd0,  1, 1, 32'h00221820, 32'h3014, D1, 1, 3'd0, 5'd0,  1, 16'd0);
        vecs[2]  = mk(1, 0, 1, 32'hFFFFFFFF, 32'h3020, D1, 1, 3'd3, 5'd0, 5'd10, 1, 1, 32'h0,        32'h3020, '0, 0, 3'd0, 5'd10, 1, 16'd0);
        vecs[3]  = mk(1, 0, 1, 32'h12345678, 32'h3024, D0, 1, 3'd2, 5'd4, 5'd10, 0, 1, 32'h0,        32'h3024, '0, 0, 3'd0, 5'd4,  0, 16'd0);
        vecs[4]  = mk(0, 0, 1, 32'hDEADBEEF, 32'h4000, D1, 1, 3'd5, 5'd0, 5'd0,  1, 1, 32'h0,        32'h3024, '0, 0, 3'd0, 5'd4,  0, 16'd0);
        vecs[5]  = mk(0, 0, 1, 32'hDEADBEEF, 32'h4004, D1, 1, 3'd5, 5'd0, 5'd0,  1, 1, 32'h0,        32'h3024, '0, 0, 3'd0, 5'd4,  0, 16'd0);
        vecs[6]  = mk(0, 0, 0, 32'hCAFEF00D, 32'h4008, D0, 0, 3'd1, 5'd7, 5'd0,  1, 1, 32'h0,        32'h3024, '0, 0, 3'd0, 5'd4,  0, 16'd0);
        vecs[7]  = mk(0, 1, 1, 32'hDEADBEEF, 32'h3030, D1, 1, 3'd5, 5'd3, 5'd0,  1, 0, 32'h0,        32'h3030, '0, 0, 3'd0, 5'd0,  1, 16'd1);
        vecs[8]  = mk(1, 0, 1, 32'h24020001, 32'h3034, D0, 0, 3'd1, 5'd0, 5'd0,  0, 1, 32'h24020001, 32'h3034, D0, 0, 3'd0, 5'd0,  0, 16'd1);
        vecs[9]  = mk(1, 1, 1, 32'h24030002, 32'h3038, D1, 1, 3'd2, 5'd0, 5'd0,  0, 0, 32'h0,        32'h3038, '0, 0, 3'd0, 5'd0,  0, 16'd2);
        vecs[10] = mk(1, 0, 0, 32'h11111111, 32'h303C, D1, 1, 3'd4, 5'd0, 5'd0,  1, 0, 32'h0,        32'h303C, '0, 0, 3'd0, 5'd0,  1, 16'd2);
        vecs[11] = mk(0, 0, 1, 32'h22222222, 32'h5000, D0, 1, 3'd4, 5'd0, 5'd0,  0, 0, 32'h0,        32'h303C, '0, 0, 3'd0, 5'd0,  1, 16'd2);
        vecs[12] = mk(1, 0, 1, 32'h0C000C00, 32'h3040, D1, 1, 3'd7, 5'd0, 5'd0,  0, 1, 32'h0C000C00, 32'h3040, D1, 1, 3'd6, 5'd0,  0, 16'd2);

        // Power-on reset while the clock runs.
        drive_a(idle);
        drive_b(idle);
        repeat (3) @(negedge clk);
        check_a("reset", 0, rst_e);
        chk("reset_b.pc", 0, 96'(b_if.pc_out), 96'h3000);
        chk("reset_b.fcnt", 0, 96'(b_if.flush_cnt), 96'd0);
        reset = 1'b1;

        // Table: the expected record is pushed when the vector is driven,
        // then popped and compared after the edge.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive_a(vecs[i].i);
            sb_q.push_back(vecs[i].e);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard[%0d]: got empty queue expected entry", i);
            end else begin
                got = sb_q.pop_front();
                check_a("vec", i, got);
            end
        end

        // Asynchronous reset with the clock stopped, during a stall.
        @(negedge clk);
        clk_run = 1'b0;
        drive_a(idle);
        #3 reset = 1'b0;
        #1 check_a("async_reset", 0, rst_e);
        #2 reset = 1'b1;
        clk_run = 1'b1;

        // dut_b: with TNEW_DEC=0, Tnew passes through unchanged.
        vb = idle;
        vb.en = 1'b1; vb.valid = 1'b1; vb.ir = 32'h8C010004; vb.pc = 32'h3100;
        vb.we = 1'b1; vb.tnew = 3'd5;
        @(negedge clk);
        drive_b(vb);
        @(posedge clk);
        #1;
        chk("b_tnew_pass", 0, 96'(b_if.tnew_out), 96'd5);
        chk("b_ir", 0, 96'(b_if.ir_out), 96'h8C010004);
        vb.tnew = 3'd0;
        @(negedge clk);
        drive_b(vb);
        @(posedge clk);
        #1;
        chk("b_tnew_pass", 1, 96'(b_if.tnew_out), 96'd0);

        // dut_b: a 2-bit flush counter stops at 3. These flushes are driven
        // with en=0.
        fexp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        vb.en = 1'b0; vb.flush = 1'b1;
        for (int k = 0; k < 5; k++) begin
            vb.pc = 32'h3200 + 32'(k * 4);
            @(negedge clk);
            drive_b(vb);
            @(posedge clk);
            #1;
            chk("b_fcnt", k, 96'(b_if.flush_cnt), 96'(fexp[k]));
        end
        chk("b_flush_pc", 0, 96'(b_if.pc_out), 96'h3210);
        chk("b_flush_valid", 0, 96'(b_if.valid_out), 96'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
